// File: rtl/seq_monitor.sv
// seq_monitor: measures high/low pulse widths and counts rising edges on four
// asynchronous pulse-train inputs, exposed through a small register port.
module seq_monitor #(
  parameter logic [7:0] REGBASE = 8'h48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  inputs,
  input  logic [15:0] reg_addr,
  inout  wire  [31:0] reg_data,
  input  logic        reg_wr
);

  localparam logic [31:0] SAT = 32'hFFFF_FFFF;

  logic             ctrl_en;
  logic [3:0]       sync1, sync2, prev;
  logic [3:0]       edge_det, rise, fall;
  logic [3:0]       armed, got_high, got_low, ovf;
  logic [3:0][31:0] run_q, run_inc, high_q, low_q, edges_q;
  logic [15:0]      offset;
  logic             ctrl_wr, clear, rd_hit;
  logic [31:0]      rd_data;
  logic [1:0]       chan;
  logic             unused_wr_bits;

  // Offset from the block base; addresses below the base wrap to large
  // values and fall outside the map.
  assign offset         = reg_addr - {8'h00, REGBASE};
  assign ctrl_wr        = reg_wr && (offset == 16'd0);
  assign clear          = ctrl_wr && reg_data[1];
  assign unused_wr_bits = ^reg_data[31:2];

  // Channel slots 1..4 in offset[4:2] map to channels 0..3.
  assign chan = offset[3:2] - 2'd1;

  assign edge_det = sync2 ^ prev;
  assign rise     = sync2 & ~prev;
  assign fall     = ~sync2 & prev;

  // CTRL register: only the enable bit is stored; clear is a one-edge pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_en <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_en <= reg_data[0];
    end
  end

  // Two-flop synchronizer plus previous-level register; runs even when disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= inputs;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Saturating increment of each run counter, shared by counting and capture.
  always_comb begin
    run_inc = '0;
    for (int n = 0; n < 4; n++) begin
      run_inc[n] = (run_q[n] == SAT) ? SAT : run_q[n] + 32'd1;
    end
  end

  // Per-channel run counting, arming and width/edge capture; clear has priority.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      run_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      edges_q  <= '0;
      armed    <= '0;
      got_high <= '0;
      got_low  <= '0;
      ovf      <= '0;
    end else if (ctrl_en) begin
      for (int n = 0; n < 4; n++) begin
        if (edge_det[n]) begin
          run_q[n] <= '0;
          armed[n] <= 1'b1;
          if (armed[n] && fall[n]) begin
            high_q[n]   <= run_inc[n];
            got_high[n] <= 1'b1;
          end
          if (armed[n] && rise[n]) begin
            low_q[n]   <= run_inc[n];
            edges_q[n] <= edges_q[n] + 32'd1;
            got_low[n] <= 1'b1;
          end
        end else begin
          run_q[n] <= run_inc[n];
          if (run_inc[n] == SAT) begin
            ovf[n] <= 1'b1;
          end
        end
      end
    end else begin
      armed <= '0;
    end
  end

  // Register read decode from registered state; unmapped offsets are not driven.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 32'h0;
    if (offset == 16'd0) begin
      rd_hit  = 1'b1;
      rd_data = {31'h0, ctrl_en};
    end else if (offset == 16'd1) begin
      rd_hit  = 1'b1;
      rd_data = {24'h0, ovf, got_high & got_low};
    end else if ((offset[15:5] == 11'h0) && (offset[4:2] >= 3'd1) &&
                 (offset[4:2] <= 3'd4) && (offset[1:0] != 2'd3)) begin
      rd_hit = 1'b1;
      case (offset[1:0])
        2'd0:    rd_data = high_q[chan];
        2'd1:    rd_data = low_q[chan];
        default: rd_data = edges_q[chan];
      endcase
    end
  end

  assign reg_data = (!reg_wr && rd_hit) ? rd_data : 32'bz;

endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter: REGBASE, default 8'h48; base register address of the block.
REQ-002 Port: clk  input  1  single clock; all logic, including the register port, is synchronous to its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; 0 sampled at a clk edge resets the block.
REQ-004 Port: inputs  input  4  asynchronous pulse-train inputs, channel n on bit n.
REQ-005 Port: reg_addr  input  16  register address.
REQ-006 Port: reg_data  inout  32  register data; write data is sampled on clk; read data is driven by this block only when addressed.
REQ-007 Port: reg_wr  input  1  1 = write cycle at reg_addr; 0 = read.

Function
REQ-008 The register map SHALL be:
- REGBASE+0: CTRL (RW); bit0 enable, bit1 clear (write-1 pulse, always reads 0).
- REGBASE+1: STATUS (RO); [3:0] valid_n, [7:4] ovf_n.
- REGBASE+4+4n: HIGH_n (RO).
- REGBASE+5+4n: LOW_n (RO).
- REGBASE+6+4n: EDGES_n (RO).
REQ-009 Read: when reg_wr=0 and reg_addr hits the map, reg_data SHALL be driven combinationally from registered state; otherwise reg_data SHALL be high-Z.
REQ-010 Write: reg_wr=1 at a CTRL address SHALL update CTRL at that clk edge; writes to RO addresses SHALL be ignored.
REQ-011 Each input SHALL pass through a 2-flop synchronizer, followed by a previous-level register; an edge is sync2 != prev.
REQ-012 Each channel SHALL keep a 32-bit run counter: 0 on any edge, otherwise +1 per cycle, saturating at 32'hFFFFFFFF.
REQ-013 Saturation SHALL set sticky ovf_n.
REQ-014 On a falling edge with armed_n=1, HIGH_n SHALL load run+1 (saturating) and valid_n[high] SHALL set.
REQ-015 On a rising edge with armed_n=1, LOW_n SHALL load run+1 (saturating), and EDGES_n SHALL increment, wrapping modulo 2^32.
REQ-016 armed_n SHALL set on the first edge after enable rises and SHALL clear while enable=0; the first partial level after enable is never captured.
REQ-017 valid_n SHALL be 1 only after both a HIGH_n and a LOW_n capture since the last clear or reset.
REQ-018 Latency: a capture register SHALL update on the 3rd clk edge after the first edge that samples the new input level.
REQ-019 A level held N clk cycles at the input SHALL read back as N; this pairs with a seq_channel count of C reading back C+1.
REQ-020 While enable=0: captures, EDGES and ovf SHALL hold, run counters SHALL hold, and synchronizers SHALL keep running.
REQ-021 Clear SHALL zero all HIGH, LOW, EDGES, run counters, valid, ovf and armed in the same edge; clear wins over a simultaneous edge or capture.
REQ-022 Channels SHALL be independent; simultaneous edges on all channels SHALL all be captured in the same cycle.

Reset
REQ-023 With reset=0 at a clk edge: CTRL=0, all capture/count/run/status registers=0, armed=0, synchronizer and prev flops=0; reg_data remains high-Z unless read.
REQ-024 Reset asserted mid-measurement SHALL discard any partial level; after release the first edge only arms the channel.

Verification
REQ-025 Enable; drive inputs[0] with 5 cycles high, 3 cycles low, repeated -> HIGH_0=5, LOW_0=3, valid_0=1, EDGES_0 increments once per period.
REQ-026 Enable mid-high-level -> no capture of that partial level; the first full low yields LOW_0 and valid stays 0 until a full HIGH is captured.
REQ-027 Hold inputs[1]=1 for more than 2^32 cycles (forced run counter near max) -> run saturates, ovf_1=1, HIGH_1=32'hFFFFFFFF on the falling edge.
REQ-028 Write CTRL=3 on the same cycle as a detected edge -> all registers 0, no capture, enable=1, clear reads 0.
REQ-029 Read REGBASE+6 with reg_wr=0 -> reg_data=EDGES_0; unmapped address -> reg_data=Z; write to HIGH_0 -> unchanged.
REQ-030 reset=0 for 1 cycle during operation -> all registers 0 next cycle; the next edge arms only.
